pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and fetch sequencer for the single-issue WISC core.
- Sits directly upstream of the next-PC/branch logic:
  - drives the current PC into that logic;
  - latches the next PC it computes;
  - fetches each instruction from instruction memory over a req/ready handshake;
  - presents the fetched word to decode.
- Owns halt sequencing and a retired-instruction counter.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address.
- DATA_W, 16, instruction word width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  ADDR_W  next PC from the branch/next-PC logic, valid in VALID state.
- stall  input  1  decode/execute not ready; hold the current instruction.
- halt  input  1  current instruction decodes as HALT.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  ADDR_W  fetch address; always equals pc.
- imem_rdata  input  DATA_W  instruction word, sampled when imem_req && imem_ready.
- imem_ready  input  1  memory returns data this cycle.
- pc  output  ADDR_W  current PC; feeds In_pc of the next-PC logic.
- instr  output  DATA_W  latched instruction word.
- instr_valid  output  1  instr is valid for decode.
- halted  output  1  core halted.
- retired  output  16  count of instructions retired, including HALT.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, all outputs and state are forced immediately:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired=0, state=IDLE.
- imem_addr is combinationally equal to pc at all times.
- All state updates occur on the rising clk edge.
- FSM states: IDLE, FETCH, VALID, HALTED.
- IDLE: imem_req=0. Moves unconditionally to FETCH on the next edge. IDLE is entered only through reset.
- FETCH:
  - imem_req=1, instr_valid=0.
  - If imem_ready=1: instr<=imem_rdata and state->VALID. instr_valid is 1 in the following cycle.
  - Otherwise stay in FETCH; imem_req and imem_addr are held stable.
  - stall and halt are ignored in this state.
- VALID:
  - imem_req=0, instr_valid=1.
  - stall=1: hold everything; pc, instr and retired are unchanged.
  - stall=0 and halt=0: pc<=next_pc; retired<=retired+1; state->FETCH. instr keeps its old value; instr_valid goes low.
  - stall=0 and halt=1: pc unchanged; retired<=retired+1; state->HALTED; next_pc is ignored.
  - stall=1 and halt=1: stall wins; nothing retires.
- HALTED:
  - halted=1, instr_valid=0, imem_req=0.
  - pc and retired are frozen; only reset exits this state.
- imem_ready is ignored outside FETCH.
- Latency:
  - Minimum 2 cycles per instruction: FETCH with ready, then VALID with no stall.
  - Each cycle of memory wait or stall adds one cycle.
- Arithmetic and wrap-around:
  - retired is modulo 2^16; 16'hFFFF+1 -> 16'h0000.
  - pc takes next_pc verbatim; the upstream logic owns wrap at 16'hFFFF -> 16'h0000, with no special handling here.
- Reset during FETCH abandons the outstanding request; imem_req drops asynchronously. Memory must tolerate a withdrawn request.
- Reset during HALTED restarts from RESET_PC via IDLE.
- No X propagation: next_pc, halt and stall are sampled only in VALID.

Test Plan:
- Reset, imem_ready tied 1, next_pc=pc+1, no stall -> pc sequence 0,1,2,3 changing every 2 cycles; retired=3 after the third VALID with stall=0; instr matches imem_rdata for each address.
- imem_ready held 0 for 5 cycles in FETCH at pc=16'h0004 -> imem_req=1 and imem_addr=16'h0004 stable throughout; instr_valid rises exactly 1 cycle after ready=1.
- In VALID, stall=1 for 3 cycles with next_pc=16'h0020 -> pc, instr and retired unchanged; after stall drops, pc=16'h0020 on the next edge.
- Taken branch: next_pc=16'hFFF0 presented in VALID -> imem_addr=16'hFFF0 in the following FETCH; next_pc=16'h0000 from pc=16'hFFFF -> clean wrap.
- halt=1, stall=0 in VALID at pc=16'h0010 -> halted=1 next cycle; pc stays 16'h0010; retired increments once, then freezes; imem_req stays 0 for 10+ cycles.
- Assert rst_n=0 mid-FETCH and again in HALTED -> outputs reset immediately (without a clock edge); after release, IDLE for 1 cycle, then FETCH at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the single-issue WISC core.
// Fetches over a req/ready handshake, presents the word to decode and counts retirements.
module pc_fetch_unit #(
  parameter int unsigned           ADDR_W   = 16,
  parameter int unsigned           DATA_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              stall,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StHalted} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [15:0]         retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // next_pc, stall and halt are only looked at in StValid so X upstream cannot leak in.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (!stall) begin
          retired_d = retired_q + 16'd1;
          if (halt) begin
            state_d = StHalted;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset forces them without a clock edge.
  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StValid);
  assign halted      = (state_q == StHalted);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;

endmodule
